// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the 'sub' request bit.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one result bit per RUN cycle, LSB first.
// IDLE -> RUN (WIDTH cycles) -> DONE (one cycle) -> IDLE.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN; b is complemented
// on capture and the carry preset to 1, giving a-b with cout = no-borrow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_c_init;

  // Full-adder slice on the current LSBs of the operand shifters.
  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = (r_cnt == LAST_BIT);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: invert b and seed the carry on capture.
  assign w_b_cap  = bus.sub ? ~bus.b : bus.b;
  assign w_c_init = bus.sub;
`else
  assign w_b_cap  = bus.b;
  assign w_c_init = 1'b0;
`endif

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered busy/done flags decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Operand capture and per-bit shifting; cout latched on the final bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_b_cap;
      r_carry <= w_c_init;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      // Counter ends at WIDTH, which fits in CW bits, so it never wraps.
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_c;
      end else begin
        r_cout <= r_cout;
      end
    end else begin
      r_a <= r_a;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The module SHALL have port a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 The module SHALL have port b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 The module SHALL have port busy  output  1  high while in RUN.
REQ-008 The module SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 The module SHALL have port sum  output  WIDTH  result register; holds its value until the next accepted start.
REQ-010 The module SHALL have port cout  output  1  final carry out of bit WIDTH-1; held with sum.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL capture a and b into shift registers, clear the carry flop, zero the bit counter and go to RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-013 Each RUN cycle SHALL compute one bit LSB-first: s = a0 ^ b0 ^ c; c_next = a0&b0 | a0&c | b0&c; s SHALL shift into sum MSB-side while both operand registers shift right by one.
REQ-014 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit the FSM SHALL go to DONE, with sum holding the full result LSB-aligned and cout equal to the final carry.
REQ-015 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally; total latency from the accepted start edge to done high SHALL be WIDTH+1 cycles.
REQ-016 start while in RUN or DONE SHALL be ignored; no queuing.
REQ-017 Changes on a or b after capture SHALL NOT affect the operation in progress.
REQ-018 sum and cout SHALL be arithmetic (a+b) mod 2^WIDTH and carry, including the wrap-around case (all-ones + 1 -> sum 0, cout 1).
REQ-019 start held high continuously SHALL start a new operation on every IDLE visit, giving one result every WIDTH+2 cycles.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, carry=0 and counter=0, regardless of clock.
REQ-022 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-023 With macro SERIAL_ADDER_SUB_EN defined, the module SHALL add input port sub (1 bit), captured on the accepted start; sub=1 SHALL complement b on capture and preset carry to 1, yielding sum = (a-b) mod 2^WIDTH and cout = 1 when a >= b (no borrow).
REQ-024 Without SERIAL_ADDER_SUB_EN, the sub port and its logic SHALL be absent and behaviour SHALL be pure addition per REQ-013.

Verification
REQ-025 WIDTH=8, a=8'h35, b=8'h4A, start one cycle -> busy high 8 cycles, done at cycle 9, sum=8'h7F, cout=0.
REQ-026 WIDTH=8, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
REQ-027 Start pulsed again during RUN with different operands -> ignored; first result unchanged; sum/cout stable through IDLE until next start.
REQ-028 rst_n low at RUN cycle 4 -> sum=0, cout=0, busy=0, no done pulse; next start with a=8'h10, b=8'h20 -> sum=8'h30.
REQ-029 SERIAL_ADDER_SUB_EN defined: a=8'h50, b=8'h20, sub=1 -> sum=8'h30, cout=1; a=8'h20, b=8'h50, sub=1 -> sum=8'hD0, cout=0.
REQ-030 start held high for 3 operations, random operands -> done every 10 cycles; each result matches reference model a+b.
